// File: rtl/tx_word_arbiter_if.sv
// Bus bundle for tx_word_arbiter: requester side, grant/status and the UART byte handshake.
// The arbiter attaches through the slave modport; the driving environment uses master.
interface tx_word_arbiter_if;
    logic [1:0]  req;
    logic [31:0] word0;
    logic [31:0] word1;
    logic [1:0]  grant;
    logic [1:0]  frame_done;
    logic        busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done_tick;

    modport slave (
        input  req,
        input  word0,
        input  word1,
        input  tx_done_tick,
        output grant,
        output frame_done,
        output busy,
        output tx_start,
        output tx_data
    );

    modport master (
        output req,
        output word0,
        output word1,
        output tx_done_tick,
        input  grant,
        input  frame_done,
        input  busy,
        input  tx_start,
        input  tx_data
    );
endinterface

// File: rtl/tx_word_arbiter.sv
// Two-requester round-robin arbiter that serialises a 32-bit word, LSB first, into UART bytes.
// Define TXARB_HEADER_EN to prefix each frame with header byte HDR_BASE | winner index.
module tx_word_arbiter #(
    parameter int unsigned BYTES    = 4,
    parameter logic [7:0]  HDR_BASE = 8'hA0
) (
    input logic              clock,
    input logic              reset,
    tx_word_arbiter_if.slave bus
);

`ifdef TXARB_HEADER_EN
    localparam int unsigned HdrLen = 1;
`else
    localparam int unsigned HdrLen = 0;
`endif
    localparam logic [2:0] LastCnt = 3'(BYTES + HdrLen - 1);

    // The winner index is OR-ed into the header, so its low bit must be free.
    localparam bit ParamsOk = (BYTES >= 1) && (BYTES <= 4) && (HDR_BASE[0] == 1'b0);
    if (!ParamsOk) begin : gen_param_err
        $error("tx_word_arbiter: BYTES must be 1..4 and HDR_BASE[0] must be 0");
    end

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWait
    } state_e;

    state_e      state_q, state_d;
    logic        rr_q, rr_d;
    logic        owner_q, owner_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] shreg_q, shreg_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  done_q, done_d;
    logic        busy_q, busy_d;
    logic        tx_start_q, tx_start_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        winner;

    assign winner = bus.req[rr_q] ? rr_q : ~rr_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            rr_q       <= 1'b0;
            owner_q    <= 1'b0;
            cnt_q      <= 3'd0;
            shreg_q    <= 32'd0;
            grant_q    <= 2'b00;
            done_q     <= 2'b00;
            busy_q     <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Outputs are computed from the next state so every one of them leaves a flop.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        grant_d    = 2'b00;
        done_d     = 2'b00;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;

        unique case (state_q)
            StIdle: begin
                if (bus.req != 2'b00) begin
                    owner_d          = winner;
                    shreg_d          = winner ? bus.word1 : bus.word0;
                    cnt_d            = 3'd0;
                    grant_d[winner]  = 1'b1;
                    tx_start_d       = 1'b1;
`ifdef TXARB_HEADER_EN
                    tx_data_d        = HDR_BASE | {7'd0, winner};
`else
                    tx_data_d        = shreg_d[7:0];
`endif
                    state_d          = StStart;
                end
            end
            StStart: begin
                state_d = StWait;
            end
            StWait: begin
                if (bus.tx_done_tick) begin
                    if (cnt_q == LastCnt) begin
                        done_d[owner_q] = 1'b1;
                        rr_d            = ~owner_q;
                        state_d         = StIdle;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
`ifdef TXARB_HEADER_EN
                        // The header byte does not consume payload.
                        if (cnt_q != 3'd0) begin
                            shreg_d = shreg_q >> 8;
                        end
`else
                        shreg_d = shreg_q >> 8;
`endif
                        tx_data_d  = shreg_d[7:0];
                        tx_start_d = 1'b1;
                        state_d    = StStart;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    assign bus.grant      = grant_q;
    assign bus.frame_done = done_q;
    assign bus.busy       = busy_q;
    assign bus.tx_start   = tx_start_q;
    assign bus.tx_data    = tx_data_q;

endmodule

// File: tb/tb_tx_word_arbiter.sv
// Directed bench for tx_word_arbiter with a UART stand-in that ticks a fixed delay after tx_start.
// Expected bytes follow the TXARB_HEADER_EN setting of the build.
module tb_tx_word_arbiter;
`ifdef TXARB_HEADER_EN
    localparam int FrameLen = 5;
`else
    localparam int FrameLen = 4;
`endif
    localparam int UartDelay = 20;
    localparam int Budget    = 200;

    logic clock = 1'b0;
    logic reset;
    logic uart_tick = 1'b0;
    logic spur_tick;
    logic uart_pend = 1'b0;
    int   uart_cnt  = 0;

    int checks = 0;
    int errors = 0;
    int cyc;
    int last_tick;

    logic [7:0] bytes_q[$];
    logic [1:0] grants_q[$];
    logic [1:0] dones_q[$];
    int         gaps_q[$];

    tx_word_arbiter_if bus ();

    assign bus.tx_done_tick = uart_tick | spur_tick;

    tx_word_arbiter #(
        .BYTES    (4),
        .HDR_BASE (8'hA0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // UART stand-in; shares the arbiter reset.
    always @(posedge clock) begin
        if (reset) begin
            uart_pend <= 1'b0;
            uart_cnt  <= 0;
            uart_tick <= 1'b0;
        end else begin
            uart_tick <= 1'b0;
            if (bus.tx_start) begin
                uart_pend <= 1'b1;
                uart_cnt  <= UartDelay;
            end else if (uart_pend) begin
                if (uart_cnt == 1) begin
                    uart_tick <= 1'b1;
                    uart_pend <= 1'b0;
                end else begin
                    uart_cnt <= uart_cnt - 1;
                end
            end
        end
    end

    initial begin
        cyc       = 0;
        last_tick = 0;
        forever begin
            @(negedge clock);
            cyc++;
            if (reset === 1'b0) begin
                if (bus.tx_done_tick === 1'b1) last_tick = cyc;
                if (bus.tx_start === 1'b1) begin
                    bytes_q.push_back(bus.tx_data);
                    gaps_q.push_back(cyc - last_tick);
                end
                if (bus.grant !== 2'b00) grants_q.push_back(bus.grant);
                if (bus.frame_done !== 2'b00) dones_q.push_back(bus.frame_done);
            end
        end
    end

    task automatic clear_logs();
        bytes_q.delete();
        grants_q.delete();
        dones_q.delete();
        gaps_q.delete();
    endtask

    task automatic wait_frame_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (bus.frame_done !== 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        spur_tick = 1'b0;
        bus.req   = 2'b11;
        bus.word0 = 32'hFFFF_FFFF;
        bus.word1 = 32'hFFFF_FFFF;
        repeat (3) @(negedge clock);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got %b want 0", bus.busy);
        end
        checks++;
        if (bus.grant !== 2'b00) begin
            errors++; $display("FAIL reset_grant got %b want 00", bus.grant);
        end
        checks++;
        if (bus.frame_done !== 2'b00) begin
            errors++; $display("FAIL reset_frame_done got %b want 00", bus.frame_done);
        end
        checks++;
        if (bus.tx_start !== 1'b0) begin
            errors++; $display("FAIL reset_tx_start got %b want 0", bus.tx_start);
        end
        checks++;
        if (bus.tx_data !== 8'h00) begin
            errors++; $display("FAIL reset_tx_data got %h want 00", bus.tx_data);
        end
        #1;
        reset   = 1'b0;
        bus.req = 2'b00;
        repeat (2) @(negedge clock);
        checks++;
        if (bus.busy !== 1'b0 || bus.grant !== 2'b00) begin
            errors++; $display("FAIL idle_no_req got busy=%b grant=%b want 0/00", bus.busy, bus.grant);
        end
    endtask

    task automatic test_single();
        logic [7:0] exp[$];
        bit ok;
`ifdef TXARB_HEADER_EN
        exp = '{8'hA0, 8'h44, 8'h33, 8'h22, 8'h11};
`else
        exp = '{8'h44, 8'h33, 8'h22, 8'h11};
`endif
        @(negedge clock); #1;
        clear_logs();
        bus.word0 = 32'h1122_3344;
        bus.req   = 2'b01;
        @(negedge clock);
        checks++;
        if (bus.grant !== 2'b01 || bus.tx_start !== 1'b1 || bus.tx_data !== exp[0]) begin
            errors++;
            $display("FAIL single_grant got grant=%b start=%b data=%h want 01/1/%h",
                     bus.grant, bus.tx_start, bus.tx_data, exp[0]);
        end
        #1 bus.req = 2'b00;
        wait_frame_done(Budget * FrameLen, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL single_timeout got no frame_done want frame_done");
        end
        checks++;
        if (dones_q.size() != 1 || dones_q[0] !== 2'b01) begin
            errors++; $display("FAIL single_done got %0d pulses want 1 of 01", dones_q.size());
        end
        checks++;
        if (grants_q.size() != 1) begin
            errors++; $display("FAIL single_grants got %0d want 1", grants_q.size());
        end
        checks++;
        if (bytes_q.size() != exp.size()) begin
            errors++; $display("FAIL single_len got %0d want %0d", bytes_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < bytes_q.size(); i++) begin
            checks++;
            if (bytes_q[i] !== exp[i]) begin
                errors++; $display("FAIL single_byte%0d got %h want %h", i, bytes_q[i], exp[i]);
            end
        end
        for (int i = 1; i < gaps_q.size(); i++) begin
            checks++;
            if (gaps_q[i] != 1) begin
                errors++; $display("FAIL single_gap%0d got %0d want 1", i, gaps_q[i]);
            end
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL single_busy_end got %b want 0", bus.busy);
        end
    endtask

    task automatic test_drop_req();
        logic [7:0] exp[$];
        bit ok;
`ifdef TXARB_HEADER_EN
        exp = '{8'hA0, 8'hD8, 8'hC7, 8'hB6, 8'hA5};
`else
        exp = '{8'hD8, 8'hC7, 8'hB6, 8'hA5};
`endif
        @(negedge clock); #1;
        clear_logs();
        bus.word0 = 32'hA5B6_C7D8;
        bus.req   = 2'b01;
        @(negedge clock);
        checks++;
        if (bus.grant !== 2'b01) begin
            errors++; $display("FAIL drop_grant got %b want 01", bus.grant);
        end
        @(negedge clock); #1;
        bus.req   = 2'b00;
        bus.word0 = 32'h0000_0000;
        wait_frame_done(Budget * FrameLen, ok);
        checks++;
        if (!ok || dones_q.size() != 1) begin
            errors++; $display("FAIL drop_done got %0d pulses want 1", dones_q.size());
        end
        checks++;
        if (bytes_q.size() != exp.size()) begin
            errors++; $display("FAIL drop_len got %0d want %0d", bytes_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < bytes_q.size(); i++) begin
            checks++;
            if (bytes_q[i] !== exp[i]) begin
                errors++; $display("FAIL drop_byte%0d got %h want %h", i, bytes_q[i], exp[i]);
            end
        end
    endtask

    task automatic test_requester1();
        logic [7:0] exp[$];
        bit ok;
`ifdef TXARB_HEADER_EN
        exp = '{8'hA1, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`else
        exp = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
`endif
        @(negedge clock); #1;
        clear_logs();
        bus.word1 = 32'hDEAD_BEEF;
        bus.req   = 2'b10;
        @(negedge clock);
        checks++;
        if (bus.grant !== 2'b10) begin
            errors++; $display("FAIL req1_grant got %b want 10", bus.grant);
        end
        #1 bus.req = 2'b00;
        wait_frame_done(Budget * FrameLen, ok);
        checks++;
        if (!ok || dones_q.size() != 1 || dones_q[0] !== 2'b10) begin
            errors++; $display("FAIL req1_done got %0d pulses want 1 of 10", dones_q.size());
        end
        checks++;
        if (bytes_q.size() != exp.size()) begin
            errors++; $display("FAIL req1_starts got %0d want %0d", bytes_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < bytes_q.size(); i++) begin
            checks++;
            if (bytes_q[i] !== exp[i]) begin
                errors++; $display("FAIL req1_byte%0d got %h want %h", i, bytes_q[i], exp[i]);
            end
        end
    endtask

    task automatic test_spurious();
        logic [7:0] exp[$];
        bit ok;
`ifdef TXARB_HEADER_EN
        exp = '{8'hA0, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
`else
        exp = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
`endif
        @(negedge clock); #1;
        clear_logs();
        spur_tick = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.busy !== 1'b0 || bus.tx_start !== 1'b0) begin
            errors++;
            $display("FAIL spur_idle got busy=%b start=%b want 0/0", bus.busy, bus.tx_start);
        end
        #1;
        spur_tick = 1'b0;
        bus.word0 = 32'hCAFE_F00D;
        bus.req   = 2'b01;
        @(negedge clock);
        checks++;
        if (bus.grant !== 2'b01 || bus.tx_start !== 1'b1) begin
            errors++;
            $display("FAIL spur_grant got grant=%b start=%b want 01/1", bus.grant, bus.tx_start);
        end
        #1;
        spur_tick = 1'b1;
        bus.req   = 2'b00;
        @(negedge clock);
        checks++;
        if (bus.tx_start !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL spur_start got start=%b busy=%b want 0/1", bus.tx_start, bus.busy);
        end
        #1 spur_tick = 1'b0;
        wait_frame_done(Budget * FrameLen, ok);
        checks++;
        if (!ok || dones_q.size() != 1) begin
            errors++; $display("FAIL spur_done got %0d pulses want 1", dones_q.size());
        end
        checks++;
        if (bytes_q.size() != exp.size()) begin
            errors++; $display("FAIL spur_len got %0d want %0d", bytes_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < bytes_q.size(); i++) begin
            checks++;
            if (bytes_q[i] !== exp[i]) begin
                errors++; $display("FAIL spur_byte%0d got %h want %h", i, bytes_q[i], exp[i]);
            end
        end
    endtask

    task automatic test_contention();
        logic [7:0] exp[$];
        logic [1:0] exp_grant[4];
        bit ok;
`ifdef TXARB_HEADER_EN
        exp = '{8'hA0, 8'h04, 8'h03, 8'h02, 8'h01, 8'hA1, 8'h08, 8'h07, 8'h06, 8'h05};
`else
        exp = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h08, 8'h07, 8'h06, 8'h05};
`endif
        exp_grant = '{2'b01, 2'b10, 2'b01, 2'b10};
        @(negedge clock); #1;
        reset     = 1'b1;
        bus.word0 = 32'h0102_0304;
        bus.word1 = 32'h0506_0708;
        bus.req   = 2'b11;
        repeat (2) @(negedge clock);
        #1;
        clear_logs();
        reset = 1'b0;
        for (int f = 0; f < 4; f++) begin
            wait_frame_done(Budget * FrameLen, ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL cont_timeout frame %0d got none want frame_done", f);
            end
        end
        bus.req = 2'b00;
        checks++;
        if (grants_q.size() != 4) begin
            errors++; $display("FAIL cont_grants got %0d want 4", grants_q.size());
        end
        for (int i = 0; i < 4 && i < grants_q.size(); i++) begin
            checks++;
            if (grants_q[i] !== exp_grant[i]) begin
                errors++; $display("FAIL cont_grant%0d got %b want %b", i, grants_q[i], exp_grant[i]);
            end
        end
        for (int i = 0; i < 4 && i < dones_q.size(); i++) begin
            checks++;
            if (dones_q[i] !== exp_grant[i]) begin
                errors++; $display("FAIL cont_done%0d got %b want %b", i, dones_q[i], exp_grant[i]);
            end
        end
        checks++;
        if (bytes_q.size() != 4 * FrameLen) begin
            errors++; $display("FAIL cont_len got %0d want %0d", bytes_q.size(), 4 * FrameLen);
        end
        for (int i = 0; i < 4 * FrameLen && i < bytes_q.size(); i++) begin
            checks++;
            if (bytes_q[i] !== exp[i % (2 * FrameLen)]) begin
                errors++;
                $display("FAIL cont_byte%0d got %h want %h", i, bytes_q[i], exp[i % (2 * FrameLen)]);
            end
        end
        for (int i = 1; i < gaps_q.size(); i++) begin
            checks++;
            if (gaps_q[i] != ((i % FrameLen == 0) ? 2 : 1)) begin
                errors++;
                $display("FAIL cont_gap%0d got %0d want %0d", i, gaps_q[i],
                         (i % FrameLen == 0) ? 2 : 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp[$];
        bit ok;
        bit seen;
`ifdef TXARB_HEADER_EN
        exp = '{8'hA0, 8'hCC, 8'hBB, 8'hAA, 8'h99};
`else
        exp = '{8'hCC, 8'hBB, 8'hAA, 8'h99};
`endif
        repeat (3) @(negedge clock);
        #1;
        clear_logs();
        bus.word0 = 32'h5566_7788;
        bus.req   = 2'b01;
        @(negedge clock);
        #1 bus.req = 2'b00;
        seen = 1'b0;
        for (int i = 0; i < Budget; i++) begin
            @(negedge clock); #1;
            if (bytes_q.size() >= 2) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL midrst_second_byte got %0d bytes want 2", bytes_q.size());
        end
        repeat (3) @(negedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.busy !== 1'b0 || bus.tx_start !== 1'b0 || bus.frame_done !== 2'b00) begin
            errors++;
            $display("FAIL midrst_outputs got busy=%b start=%b done=%b want 0/0/00",
                     bus.busy, bus.tx_start, bus.frame_done);
        end
        #1 reset = 1'b0;
        repeat (40) @(negedge clock);
        #1;
        checks++;
        if (dones_q.size() != 0 || bytes_q.size() != 2) begin
            errors++;
            $display("FAIL midrst_abandon got dones=%0d bytes=%0d want 0/2",
                     dones_q.size(), bytes_q.size());
        end
        clear_logs();
        bus.word0 = 32'h99AA_BBCC;
        bus.req   = 2'b01;
        @(negedge clock);
        checks++;
        if (bus.grant !== 2'b01 || bus.tx_data !== exp[0]) begin
            errors++;
            $display("FAIL midrst_regrant got grant=%b data=%h want 01/%h",
                     bus.grant, bus.tx_data, exp[0]);
        end
        #1 bus.req = 2'b00;
        wait_frame_done(Budget * FrameLen, ok);
        checks++;
        if (!ok || bytes_q.size() != exp.size()) begin
            errors++;
            $display("FAIL midrst_frame got %0d bytes want %0d", bytes_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < bytes_q.size(); i++) begin
            checks++;
            if (bytes_q[i] !== exp[i]) begin
                errors++; $display("FAIL midrst_byte%0d got %h want %h", i, bytes_q[i], exp[i]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        spur_tick = 1'b0;
        bus.req   = 2'b00;
        bus.word0 = 32'd0;
        bus.word1 = 32'd0;
        test_reset();
        test_single();
        test_drop_req();
        test_requester1();
        test_spurious();
        test_contention();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
